mem_access_stage: RTL and testbench

Parametrised MEM stage of the pipelined MIPS core, sitting between the EX/MEM (XM_*) and MEM/WB (MW_*) pipeline registers. It owns the data memory and executes byte, halfword and word loads and stores with sign or zero extension. Data-memory latency is configurable and is covered by a stall handshake to EX. Non-memory instructions pass ALU results, destination register and compare flags through to write-back in one cycle.

---
 rtl/mem_access_stage_pkg.sv | 92 +++++++++
 rtl/mem_access_stage_dmem_bank.sv | 23 ++
 rtl/mem_access_stage.sv | 165 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Memory-op encoding and the lane/extension/alignment helpers shared by the
// EX decoder, the MEM stage and its bench.
package mem_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } mem_op_e;

  // Encodings 9..15 are reserved and behave as a plain pass-through.
  function automatic mem_op_e decode_op(input logic [3:0] raw);
    mem_op_e op;
    case (raw)
      4'd1:    op = OP_LB;
      4'd2:    op = OP_LBU;
      4'd3:    op = OP_LH;
      4'd4:    op = OP_LHU;
      4'd5:    op = OP_LW;
      4'd6:    op = OP_SB;
      4'd7:    op = OP_SH;
      4'd8:    op = OP_SW;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

  function automatic logic is_load(input mem_op_e op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic misaligned(input mem_op_e op, input logic [1:0] off);
    logic bad;
    case (op)
      OP_LH, OP_LHU, OP_SH: bad = off[0];
      OP_LW, OP_SW:         bad = (off != 2'b00);
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Little-endian lane select followed by sign or zero extension.
  function automatic logic [31:0] load_extract(input mem_op_e op, input logic [31:0] word,
                                               input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'h000000, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_be(input mem_op_e op, input logic [1:0] off);
    logic [3:0] be;
    case (op)
      OP_SB:   be = 4'b0001 << off;
      OP_SH:   be = off[1] ? 4'b1100 : 4'b0011;
      OP_SW:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data onto every lane; byte enables pick the lane.
  function automatic logic [31:0] store_lanes(input mem_op_e op, input logic [31:0] data);
    logic [31:0] w;
    case (op)
      OP_SB:   w = {4{data[7:0]}};
      OP_SH:   w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_access_stage_dmem_bank.sv
// Data-memory bank: 2^ADDR_W x 32 single-port RAM with per-byte write enables.
// Read data is registered downstream by the MEM/WB register.
module dmem_bank #(
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: byte/halfword/word loads and stores against a local data memory,
// with a LAT-cycle stall handshake to EX and ALU pass-through for other ops.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        XM_valid,
  output logic        XM_ready,
  input  logic [31:0] XM_ALUout,
  input  logic [31:0] XM_storeData,
  input  logic [4:0]  XM_RD,
  input  logic [3:0]  XM_memOp,
  input  logic [2:0]  XM_compareFlag,
  output logic        MW_valid,
  output logic [31:0] MW_ALUout,
  output logic [4:0]  MW_RD,
  output logic [2:0]  MW_compareFlag,
  output logic        MW_misalign
);

  localparam int unsigned CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             retire, capture;

  mem_op_e          cap_op;
  logic [31:0]      cap_addr, cap_data;
  logic [4:0]       cap_rd;
  logic [2:0]       cap_flag;

  mem_op_e          cur_op;
  logic [31:0]      cur_addr, cur_data;
  logic [4:0]       cur_rd;
  logic [2:0]       cur_flag;
  logic             cur_mem, cur_mis;

  logic [3:0]       mem_be;
  logic [31:0]      mem_rdata;

  // While BUSY the memory is driven from the captured op so EX may hold or change its inputs.
  always_comb begin
    if (state == S_BUSY) begin
      cur_op   = cap_op;
      cur_addr = cap_addr;
      cur_data = cap_data;
      cur_rd   = cap_rd;
      cur_flag = cap_flag;
    end else begin
      cur_op   = decode_op(XM_memOp);
      cur_addr = XM_ALUout;
      cur_data = XM_storeData;
      cur_rd   = XM_RD;
      cur_flag = XM_compareFlag;
    end
    cur_mem = is_load(cur_op) || is_store(cur_op);
    cur_mis = misaligned(cur_op, cur_addr[1:0]);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retire    = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (XM_valid) begin
          if (cur_mem && (LAT > 1)) begin
            capture   = 1'b1;
            state_nxt = S_BUSY;
            cnt_nxt   = CNT_W'(LAT - 1);
          end else begin
            retire = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (cnt == CNT_W'(1)) begin
          retire    = 1'b1;
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign XM_ready = (state == S_IDLE);

  // Reset gates the write so an aborted or in-reset store can never commit.
  assign mem_be = (rst && retire && is_store(cur_op) && !cur_mis)
                  ? store_be(cur_op, cur_addr[1:0]) : '0;

  dmem_bank #(
    .ADDR_W(ADDR_W)
  ) u_dmem (
    .clk  (clk),
    .addr (cur_addr[ADDR_W+1:2]),
    .be   (mem_be),
    .wdata(store_lanes(cur_op, cur_data)),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_op   <= OP_NONE;
      cap_addr <= '0;
      cap_data <= '0;
      cap_rd   <= '0;
      cap_flag <= '0;
    end else if (capture) begin
      cap_op   <= cur_op;
      cap_addr <= cur_addr;
      cap_data <= cur_data;
      cap_rd   <= cur_rd;
      cap_flag <= cur_flag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MW_valid       <= 1'b0;
      MW_ALUout      <= '0;
      MW_RD          <= '0;
      MW_compareFlag <= '0;
      MW_misalign    <= 1'b0;
    end else if (retire) begin
      MW_valid       <= 1'b1;
      MW_compareFlag <= cur_flag;
      MW_misalign    <= cur_mis;
      MW_RD          <= (is_store(cur_op) || cur_mis || (cur_flag != 3'd0)) ? '0 : cur_rd;
      MW_ALUout      <= (is_load(cur_op) && !cur_mis)
                        ? load_extract(cur_op, mem_rdata, cur_addr[1:0]) : cur_addr;
    end else begin
      MW_valid    <= 1'b0;
      MW_RD       <= '0;
      MW_misalign <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: LAT=1 and LAT=3 instances checked against a
// byte-addressed memory model.
module tb_mem_access_stage;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst3, valid1, valid3;
  logic [31:0] alu, sd;
  logic [4:0]  rd;
  logic [3:0]  op;
  logic [2:0]  flag;

  logic        rdy1, mv1, mmis1, rdy3, mv3, mmis3;
  logic [31:0] ma1, ma3;
  logic [4:0]  mrd1, mrd3;
  logic [2:0]  mfl1, mfl3;

  int checks = 0;
  int errors = 0;

  logic [7:0] mb [2][512];

  mem_access_stage #(.ADDR_W(7), .LAT(1)) u_lat1 (
    .clk(clk), .rst(rst1), .XM_valid(valid1), .XM_ready(rdy1), .XM_ALUout(alu),
    .XM_storeData(sd), .XM_RD(rd), .XM_memOp(op), .XM_compareFlag(flag),
    .MW_valid(mv1), .MW_ALUout(ma1), .MW_RD(mrd1), .MW_compareFlag(mfl1), .MW_misalign(mmis1)
  );

  mem_access_stage #(.ADDR_W(7), .LAT(3)) u_lat3 (
    .clk(clk), .rst(rst3), .XM_valid(valid3), .XM_ready(rdy3), .XM_ALUout(alu),
    .XM_storeData(sd), .XM_RD(rd), .XM_memOp(op), .XM_compareFlag(flag),
    .MW_valid(mv3), .MW_ALUout(ma3), .MW_RD(mrd3), .MW_compareFlag(mfl3), .MW_misalign(mmis3)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] d;
    logic [4:0]  rd;
    logic [2:0]  fl;
    logic [31:0] ea;
    logic [4:0]  er;
    logic        em;
    bit          ca;
  } dir_t;

  // Reference: 512-byte memory per instance, access size and signedness from the opcode.
  task automatic model_op(input int w, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] d, input logic [4:0] r, input logic [2:0] f,
                          output logic [31:0] ea, output logic [4:0] er, output logic em,
                          output bit ca);
    int size;
    bit ld, st, sgn;
    logic [8:0] base;
    longint v;
    size = 0; ld = 0; st = 0; sgn = 0;
    case (o)
      OP_LB:   begin ld = 1; sgn = 1; size = 1; end
      OP_LBU:  begin ld = 1; size = 1; end
      OP_LH:   begin ld = 1; sgn = 1; size = 2; end
      OP_LHU:  begin ld = 1; size = 2; end
      OP_LW:   begin ld = 1; size = 4; end
      OP_SB:   begin st = 1; size = 1; end
      OP_SH:   begin st = 1; size = 2; end
      OP_SW:   begin st = 1; size = 4; end
      default: ;
    endcase
    base = a[8:0];
    em = (size > 1) && ((int'(base) % size) != 0);
    ea = a;
    ca = !(st || em);
    er = (st || em || f != 3'd0) ? 5'd0 : r;
    if (st && !em)
      for (int k = 0; k < size; k++) mb[w][base + 9'(k)] = d[8*k +: 8];
    if (ld && !em) begin
      v = 0;
      for (int k = 0; k < size; k++) v = v | (longint'(mb[w][base + 9'(k)]) << (8*k));
      if (sgn && v[8*size-1]) v = v - (longint'(1) << (8*size));
      ea = v[31:0];
    end
  endtask

  function automatic logic [3:0] rand_op();
    int r;
    r = $urandom_range(0, 19);
    if (r < 9) return 4'(r);
    else if (r < 18) return 4'($urandom_range(1, 8));
    else return 4'($urandom_range(9, 15));
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 3))
      0:       a = $urandom;
      3:       a = 32'($urandom_range(0, 511));
      default: a = 32'($urandom_range(0, 63));
    endcase
    if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic issue1(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] r, input logic [2:0] f,
                        output logic ov, output logic [31:0] oa, output logic [4:0] orr,
                        output logic [2:0] of, output logic om);
    op = o; alu = a; sd = d; rd = r; flag = f; valid1 = 1'b1;
    @(posedge clk); #1;
    valid1 = 1'b0;
    ov = mv1; oa = ma1; orr = mrd1; of = mfl1; om = mmis1;
  endtask

  // Drives one op, scrambles the inputs after acceptance, then waits (bounded) for MW_valid.
  task automatic issue3(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] r, input logic [2:0] f,
                        output logic ov, output logic [31:0] oa, output logic [4:0] orr,
                        output logic [2:0] of, output logic om,
                        output int lat, output int low, output logic rb);
    op = o; alu = a; sd = d; rd = r; flag = f; valid3 = 1'b1;
    rb = rdy3;
    @(posedge clk); #1;
    valid3 = 1'b0;
    op = 4'($urandom); alu = $urandom; sd = $urandom; rd = 5'($urandom); flag = 3'($urandom);
    lat = 1; low = 0;
    while (mv3 !== 1'b1 && lat < 12) begin
      if (rdy3 === 1'b0) low++;
      @(posedge clk); #1;
      lat++;
    end
    ov = mv3; oa = ma3; orr = mrd3; of = mfl3; om = mmis3;
  endtask

  task automatic test_reset();
    rst1 = 1'b0; rst3 = 1'b0; valid1 = 1'b0; valid3 = 1'b0;
    op = '0; alu = '0; sd = '0; rd = '0; flag = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mv1, ma1, mrd1, mfl1, mmis1} !== 42'd0 || rdy1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_lat1: got v=%b alu=%h rd=%0d flag=%0d mis=%b rdy=%b, want all 0 rdy=1",
               mv1, ma1, mrd1, mfl1, mmis1, rdy1);
    end
    checks++;
    if ({mv3, ma3, mrd3, mfl3, mmis3} !== 42'd0 || rdy3 !== 1'b1) begin
      errors++;
      $display("FAIL reset_lat3: got v=%b alu=%h rd=%0d flag=%0d mis=%b rdy=%b, want all 0 rdy=1",
               mv3, ma3, mrd3, mfl3, mmis3, rdy3);
    end
    rst1 = 1'b1; rst3 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rdy1 !== 1'b1 || rdy3 !== 1'b1 || mv1 !== 1'b0 || mv3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy1=%b rdy3=%b v1=%b v3=%b, want 1 1 0 0", rdy1, rdy3, mv1, mv3);
    end
  endtask

  task automatic fill_memories();
    logic ov, om, rb; logic [31:0] oa, ea; logic [4:0] orr, er; logic [2:0] of;
    logic em; bit ca; int lat, low; logic [31:0] d;
    for (int w = 0; w < 128; w++) begin
      d = $urandom;
      model_op(0, OP_SW, 32'(w*4), d, 5'd0, 3'd0, ea, er, em, ca);
      issue1(OP_SW, 32'(w*4), d, 5'd0, 3'd0, ov, oa, orr, of, om);
      d = $urandom;
      model_op(1, OP_SW, 32'(w*4), d, 5'd0, 3'd0, ea, er, em, ca);
      issue3(OP_SW, 32'(w*4), d, 5'd0, 3'd0, ov, oa, orr, of, om, lat, low, rb);
    end
  endtask

  task automatic test_directed_lat1();
    dir_t tab [16];
    logic ov, om; logic [31:0] oa, ea; logic [4:0] orr, er; logic [2:0] of; logic em; bit ca;
    tab = '{
      '{OP_SW,   32'h10,  32'hDEADBEEF, 5'd3, 3'd0, 32'h0,        5'd0, 1'b0, 1'b0},
      '{OP_LW,   32'h10,  32'h0,        5'd5, 3'd0, 32'hDEADBEEF, 5'd5, 1'b0, 1'b1},
      '{OP_LB,   32'h13,  32'h0,        5'd6, 3'd0, 32'hFFFFFFDE, 5'd6, 1'b0, 1'b1},
      '{OP_LBU,  32'h13,  32'h0,        5'd6, 3'd0, 32'h000000DE, 5'd6, 1'b0, 1'b1},
      '{OP_LH,   32'h12,  32'h0,        5'd8, 3'd0, 32'hFFFFDEAD, 5'd8, 1'b0, 1'b1},
      '{OP_LHU,  32'h12,  32'h0,        5'd8, 3'd0, 32'h0000DEAD, 5'd8, 1'b0, 1'b1},
      '{OP_SB,   32'h11,  32'h12345655, 5'd0, 3'd0, 32'h0,        5'd0, 1'b0, 1'b0},
      '{OP_LW,   32'h10,  32'h0,        5'd5, 3'd0, 32'hDEAD55EF, 5'd5, 1'b0, 1'b1},
      '{OP_LW,   32'h12,  32'h0,        5'd5, 3'd0, 32'h0,        5'd0, 1'b1, 1'b0},
      '{OP_SH,   32'h13,  32'h0000AAAA, 5'd0, 3'd0, 32'h0,        5'd0, 1'b1, 1'b0},
      '{OP_LW,   32'h10,  32'h0,        5'd5, 3'd0, 32'hDEAD55EF, 5'd5, 1'b0, 1'b1},
      '{OP_SW,   32'h210, 32'hCAFEF00D, 5'd0, 3'd0, 32'h0,        5'd0, 1'b0, 1'b0},
      '{OP_LW,   32'h10,  32'h0,        5'd4, 3'd0, 32'hCAFEF00D, 5'd4, 1'b0, 1'b1},
      '{OP_NONE, 32'h1,   32'h0,        5'd7, 3'd2, 32'h1,        5'd0, 1'b0, 1'b1},
      '{OP_NONE, 32'h1,   32'h0,        5'd7, 3'd0, 32'h1,        5'd7, 1'b0, 1'b1},
      '{4'd12,   32'hABCD, 32'h0,       5'd3, 3'd0, 32'hABCD,     5'd3, 1'b0, 1'b1}
    };
    for (int i = 0; i < 16; i++) begin
      model_op(0, tab[i].op, tab[i].a, tab[i].d, tab[i].rd, tab[i].fl, ea, er, em, ca);
      checks++;
      if (rdy1 !== 1'b1) begin
        errors++;
        $display("FAIL dir_ready[%0d]: got %b, want 1", i, rdy1);
      end
      issue1(tab[i].op, tab[i].a, tab[i].d, tab[i].rd, tab[i].fl, ov, oa, orr, of, om);
      checks++;
      if (ov !== 1'b1 || orr !== tab[i].er || om !== tab[i].em || of !== tab[i].fl ||
          (tab[i].ca && oa !== tab[i].ea)) begin
        errors++;
        $display("FAIL dir[%0d] op=%0d addr=%h: got v=%b alu=%h rd=%0d flag=%0d mis=%b, want v=1 alu=%h rd=%0d flag=%0d mis=%b",
                 i, tab[i].op, tab[i].a, ov, oa, orr, of, om, tab[i].ea, tab[i].er, tab[i].fl, tab[i].em);
      end
    end
  endtask

  task automatic test_bubble_lat1();
    logic ov, om; logic [31:0] oa, ea; logic [4:0] orr, er; logic [2:0] of; logic em; bit ca;
    model_op(0, OP_LH, 32'h21, 32'h0, 5'd9, 3'd0, ea, er, em, ca);
    issue1(OP_LH, 32'h21, 32'h0, 5'd9, 3'd0, ov, oa, orr, of, om);
    checks++;
    if (ov !== 1'b1 || om !== 1'b1 || orr !== 5'd0) begin
      errors++;
      $display("FAIL bubble_mis: got v=%b mis=%b rd=%0d, want 1 1 0", ov, om, orr);
    end
    @(posedge clk); #1;
    checks++;
    if (mv1 !== 1'b0 || mrd1 !== 5'd0 || mmis1 !== 1'b0) begin
      errors++;
      $display("FAIL bubble_idle: got v=%b rd=%0d mis=%b, want 0 0 0", mv1, mrd1, mmis1);
    end
  endtask

  task automatic test_random_lat1();
    logic ov, om; logic [31:0] oa, ea, a, d; logic [4:0] orr, er, r; logic [2:0] of, f;
    logic [3:0] o; logic em; bit ca;
    for (int i = 0; i < 300; i++) begin
      o = rand_op(); a = rand_addr(); d = $urandom; r = 5'($urandom);
      f = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      model_op(0, o, a, d, r, f, ea, er, em, ca);
      issue1(o, a, d, r, f, ov, oa, orr, of, om);
      checks++;
      if (ov !== 1'b1 || orr !== er || om !== em || of !== f || (ca && oa !== ea)) begin
        errors++;
        $display("FAIL rand1[%0d] op=%0d addr=%h: got v=%b alu=%h rd=%0d flag=%0d mis=%b, want v=1 alu=%h rd=%0d flag=%0d mis=%b",
                 i, o, a, ov, oa, orr, of, om, ea, er, f, em);
      end
    end
  endtask

  task automatic test_back_to_back_lat3();
    logic ov, om, rb; logic [31:0] oa, ea; logic [4:0] orr, er; logic [2:0] of; logic em; bit ca;
    int lat, low;
    logic [3:0]  ops   [4] = '{OP_LW, OP_LW, OP_SW, OP_LW};
    logic [31:0] addrs [4] = '{32'h20, 32'h24, 32'h30, 32'h30};
    for (int i = 0; i < 4; i++) begin
      model_op(1, ops[i], addrs[i], 32'h11223344, 5'(i + 1), 3'd0, ea, er, em, ca);
      issue3(ops[i], addrs[i], 32'h11223344, 5'(i + 1), 3'd0, ov, oa, orr, of, om, lat, low, rb);
      checks++;
      if (rb !== 1'b1 || lat != 3 || low != 2 || ov !== 1'b1 || orr !== er || om !== 1'b0 ||
          (ca && oa !== ea) || (i == 3 && oa !== 32'h11223344)) begin
        errors++;
        $display("FAIL b2b3[%0d]: got rdy=%b lat=%0d low=%0d v=%b alu=%h rd=%0d mis=%b, want rdy=1 lat=3 low=2 v=1 alu=%h rd=%0d mis=0",
                 i, rb, lat, low, ov, oa, orr, om, ea, er);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (mv3 !== 1'b0 || mrd3 !== 5'd0 || rdy3 !== 1'b1) begin
      errors++;
      $display("FAIL pulse3: got v=%b rd=%0d rdy=%b, want 0 0 1", mv3, mrd3, rdy3);
    end
  endtask

  task automatic test_reset_busy_lat3();
    logic ov, om, rb; logic [31:0] oa, ea, old; logic [4:0] orr, er; logic [2:0] of; logic em; bit ca;
    int lat, low;
    model_op(1, OP_NONE, 32'h1234, 32'h0, 5'd4, 3'd3, ea, er, em, ca);
    issue3(OP_NONE, 32'h1234, 32'h0, 5'd4, 3'd3, ov, oa, orr, of, om, lat, low, rb);
    checks++;
    if (lat != 1 || oa !== 32'h1234 || of !== 3'd3 || orr !== 5'd0) begin
      errors++;
      $display("FAIL none3: got lat=%0d alu=%h flag=%0d rd=%0d, want 1 00001234 3 0", lat, oa, of, orr);
    end
    old = {mb[1][9'h43], mb[1][9'h42], mb[1][9'h41], mb[1][9'h40]};
    op = OP_SW; alu = 32'h40; sd = ~old; rd = 5'd0; flag = 3'd0; valid3 = 1'b1;
    @(posedge clk); #1;
    valid3 = 1'b0;
    checks++;
    if (rdy3 !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready3: got %b, want 0", rdy3);
    end
    #2 rst3 = 1'b0;
    #1;
    checks++;
    if ({mv3, ma3, mrd3, mfl3, mmis3} !== 42'd0 || rdy3 !== 1'b1) begin
      errors++;
      $display("FAIL abort3: got v=%b alu=%h rd=%0d flag=%0d mis=%b rdy=%b, want all 0 rdy=1",
               mv3, ma3, mrd3, mfl3, mmis3, rdy3);
    end
    @(posedge clk); #1;
    rst3 = 1'b1;
    model_op(1, OP_LW, 32'h40, 32'h0, 5'd9, 3'd0, ea, er, em, ca);
    issue3(OP_LW, 32'h40, 32'h0, 5'd9, 3'd0, ov, oa, orr, of, om, lat, low, rb);
    checks++;
    if (lat != 3 || ov !== 1'b1 || oa !== old || oa !== ea || orr !== 5'd9) begin
      errors++;
      $display("FAIL abort_load3: got lat=%0d v=%b alu=%h rd=%0d, want lat=3 v=1 alu=%h rd=9", lat, ov, oa, orr, old);
    end
  endtask

  task automatic test_random_lat3();
    logic ov, om, rb; logic [31:0] oa, ea, a, d; logic [4:0] orr, er, r; logic [2:0] of, f;
    logic [3:0] o; logic em; bit ca; int lat, low, elat;
    for (int i = 0; i < 60; i++) begin
      o = rand_op(); a = rand_addr(); d = $urandom; r = 5'($urandom);
      f = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      elat = (o >= 4'd1 && o <= 4'd8) ? 3 : 1;
      model_op(1, o, a, d, r, f, ea, er, em, ca);
      issue3(o, a, d, r, f, ov, oa, orr, of, om, lat, low, rb);
      checks++;
      if (rb !== 1'b1 || lat != elat || low != elat - 1 || ov !== 1'b1 || orr !== er ||
          om !== em || of !== f || (ca && oa !== ea)) begin
        errors++;
        $display("FAIL rand3[%0d] op=%0d addr=%h: got rdy=%b lat=%0d low=%0d v=%b alu=%h rd=%0d flag=%0d mis=%b, want lat=%0d alu=%h rd=%0d flag=%0d mis=%b",
                 i, o, a, rb, lat, low, ov, oa, orr, of, om, elat, ea, er, f, em);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    fill_memories();
    test_directed_lat1();
    test_bubble_lat1();
    test_random_lat1();
    test_back_to_back_lat3();
    test_reset_busy_lat3();
    test_random_lat3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
